instr_fetch: RTL and testbench

Byte-serial instruction fetch responder for the 8-bit MIPS core. It consumes the 2-bit phase code emitted by the control unit: 0 = fetch, 1 = decode, 2 = execute. On entry to the fetch phase it reads four consecutive bytes from the 8-bit instruction memory over a req/ack handshake. It assembles them little-endian into a 32-bit instruction register and advances the PC by 4. The block sits between the control unit and instruction memory, and feeds the decoder.

---
 rtl/instr_fetch.sv | 147 ++++++++++++++
 tb/tb_instr_fetch.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Byte-serial instruction fetch: on entry to the fetch phase, reads four bytes over req/ack,
// assembles them little-endian into a 32-bit instruction and advances the PC by 4.
module instr_fetch #(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  phase,
  output logic        mem_req,
  output logic [7:0]  mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        busy,
  output logic [7:0]  pc,
  output logic        fetch_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ERR} state_e;

  state_e      state_q, state_d;
  logic [1:0]  prev_phase_q;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  wait_q, wait_d;
  logic        mem_req_q, mem_req_d;
  logic [7:0]  mem_addr_q, mem_addr_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic [7:0]  pc_q, pc_d;
  logic        err_q, err_d;

  logic trigger;
  logic timeout_hit;

  assign trigger     = (phase == 2'd0) && (prev_phase_q != 2'd0);
  // Abort on the edge where the wait counter would reach TIMEOUT.
  assign timeout_hit = ({1'b0, wait_q} + 9'd1) == 9'(TIMEOUT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (trigger) state_d = S_REQ;
      S_REQ: begin
        if (mem_ack) begin
          if (byte_idx_q == 2'd3) state_d = S_IDLE;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    byte_idx_d = byte_idx_q;
    wait_d     = wait_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    pc_d       = pc_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
          busy_d     = 1'b1;
          valid_d    = 1'b0;
          byte_idx_d = '0;
          wait_d     = '0;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          instr_d[8*byte_idx_q +: 8] = mem_rdata;
          wait_d = '0;
          if (byte_idx_q == 2'd3) begin
            mem_req_d = 1'b0;
            busy_d    = 1'b0;
            valid_d   = 1'b1;
            pc_d      = pc_q + 8'd4;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            mem_addr_d = pc_q + {6'b0, byte_idx_q} + 8'd1;
          end
        end else begin
          wait_d = wait_q + 8'd1;
          if (timeout_hit) begin
            mem_req_d = 1'b0;
            busy_d    = 1'b0;
            err_d     = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_phase_q <= 2'd3;
      byte_idx_q   <= '0;
      wait_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= RESET_PC;
      instr_q      <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      pc_q         <= RESET_PC;
      err_q        <= 1'b0;
    end else begin
      prev_phase_q <= phase;
      byte_idx_q   <= byte_idx_d;
      wait_q       <= wait_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      pc_q         <= pc_d;
      err_q        <= err_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign busy        = busy_q;
  assign pc          = pc_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: byte memory modelled as an array, ack gated per edge.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic [1:0]  phase;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        busy;
  logic [7:0]  pc;
  logic        fetch_err;

  logic        ack_en;
  logic        force_ack;
  logic [7:0]  mem [256];

  int unsigned n_checks;
  int unsigned n_fail;

  assign mem_ack   = (mem_req & ack_en) | force_ack;
  assign mem_rdata = mem[mem_addr];

  instr_fetch #(.RESET_PC(8'h00), .TIMEOUT(3)) dut (
    .clk(clk), .reset(reset), .phase(phase),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid), .busy(busy), .pc(pc), .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Leave phase nonzero for one edge, then trigger with zero-wait memory through completion.
  task automatic quick_fetch();
    phase  = 2'd1;
    ack_en = 1'b1;
    step(1);
    phase = 2'd0;
    step(5);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    phase     = 2'd1;
    ack_en    = 1'b1;
    force_ack = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33; mem[8'h03] = 8'h44;
    mem[8'h04] = 8'hA1; mem[8'h05] = 8'hB2; mem[8'h06] = 8'hC3; mem[8'h07] = 8'hD4;
    mem[8'h08] = 8'h01; mem[8'h09] = 8'h02; mem[8'h0A] = 8'h03; mem[8'h0B] = 8'h04;
    mem[8'hFC] = 8'hDE; mem[8'hFD] = 8'hAD; mem[8'hFE] = 8'hBE; mem[8'hFF] = 8'hEF;

    step(2);
    check("rst_req",   32'(mem_req),     32'd0);
    check("rst_addr",  32'(mem_addr),    32'h00);
    check("rst_instr", instr,            32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_pc",    32'(pc),          32'h00);
    check("rst_err",   32'(fetch_err),   32'd0);
    reset = 1'b0;
    step(1);

    // Zero-wait fetch; phase then stays at 0 for ten cycles in total
    phase = 2'd0;
    step(1);
    check("zw_req_T",  32'(mem_req),  32'd1);
    check("zw_busy_T", 32'(busy),     32'd1);
    check("zw_addr_0", 32'(mem_addr), 32'h00);
    for (int k = 1; k <= 3; k++) begin
      step(1);
      check("zw_addr_k", 32'(mem_addr), 32'(k));
    end
    check("zw_valid_early", 32'(instr_valid), 32'd0);
    step(1);
    check("zw_valid", 32'(instr_valid), 32'd1);
    check("zw_instr", instr,            32'h44332211);
    check("zw_pc",    32'(pc),          32'h04);
    check("zw_req_lo", 32'(mem_req),    32'd0);
    check("zw_busy_lo", 32'(busy),      32'd0);
    for (int k = 0; k < 5; k++) begin
      step(1);
      check("hold0_busy", 32'(busy), 32'd0);
    end
    check("hold0_pc", 32'(pc), 32'h04);

    // Stray ack while idle must not disturb anything
    phase     = 2'd1;
    force_ack = 1'b1;
    step(2);
    force_ack = 1'b0;
    check("idle_ack_instr", instr,            32'h44332211);
    check("idle_ack_valid", 32'(instr_valid), 32'd1);
    check("idle_ack_addr",  32'(mem_addr),    32'h03);

    // Two wait cycles on byte 1: ack pattern for edges T+1..T+6 = 1,0,0,1,1,1
    phase = 2'd0;
    step(1);
    check("ws_addr_T",  32'(mem_addr),    32'h04);
    check("ws_valid_T", 32'(instr_valid), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      ack_en = (k == 2 || k == 3) ? 1'b0 : 1'b1;
      step(1);
      check("ws_err", 32'(fetch_err), 32'd0);
      if (k < 6) begin
        check("ws_busy",  32'(busy),        32'd1);
        check("ws_valid", 32'(instr_valid), 32'd0);
      end
      if (k == 3) check("ws_addr_hold", 32'(mem_addr), 32'h05);
    end
    ack_en = 1'b1;
    check("ws_valid_done", 32'(instr_valid), 32'd1);
    check("ws_instr",      instr,            32'hD4C3B2A1);
    check("ws_pc",         32'(pc),          32'h08);

    // Slow fetch while phase cycles 1,2,0: triggers during busy are ignored
    phase = 2'd1;
    step(1);
    phase = 2'd0;
    step(1);
    check("tr_addr_T", 32'(mem_addr), 32'h08);
    for (int k = 0; k < 12; k++) begin
      phase  = 2'((k + 1) % 3);
      ack_en = (k % 3 == 2) ? 1'b1 : 1'b0;
      step(1);
      if (k < 11) check("tr_busy", 32'(busy), 32'd1);
    end
    ack_en = 1'b1;
    check("tr_valid", 32'(instr_valid), 32'd1);
    check("tr_instr", instr,            32'h04030201);
    check("tr_pc",    32'(pc),          32'h0C);
    check("tr_err",   32'(fetch_err),   32'd0);
    phase = 2'd1;
    step(2);
    check("tr_no_refetch_busy", 32'(busy),    32'd0);
    check("tr_no_refetch_req",  32'(mem_req), 32'd0);
    check("tr_no_refetch_pc",   32'(pc),      32'h0C);

    // Advance pc from 0C to FC, then fetch across the wrap
    for (int i = 0; i < 60; i++) quick_fetch();
    check("wrap_pc_pre", 32'(pc), 32'hFC);
    phase = 2'd1;
    step(1);
    phase = 2'd0;
    step(1);
    check("wrap1_addr0", 32'(mem_addr), 32'hFC);
    for (int k = 1; k <= 3; k++) begin
      step(1);
      check("wrap1_addr_k", 32'(mem_addr), 32'(8'hFC + 8'(k)));
    end
    step(1);
    check("wrap1_instr", instr,   32'hEFBEADDE);
    check("wrap1_pc",    32'(pc), 32'h00);
    phase = 2'd1;
    step(1);
    phase = 2'd0;
    step(1);
    check("wrap2_addr0", 32'(mem_addr), 32'h00);
    for (int k = 1; k <= 3; k++) begin
      step(1);
      check("wrap2_addr_k", 32'(mem_addr), 32'(k));
    end
    step(1);
    check("wrap2_instr", instr,   32'h44332211);
    check("wrap2_pc",    32'(pc), 32'h04);

    // Timeout with TIMEOUT=3: ack never arrives
    phase = 2'd1;
    step(1);
    phase  = 2'd0;
    ack_en = 1'b0;
    step(1);
    check("to_req_T", 32'(mem_req), 32'd1);
    step(2);
    check("to_req_2", 32'(mem_req),   32'd1);
    check("to_err_2", 32'(fetch_err), 32'd0);
    step(1);
    check("to_req_3",  32'(mem_req),   32'd0);
    check("to_err_3",  32'(fetch_err), 32'd1);
    check("to_busy_3", 32'(busy),      32'd0);
    check("to_pc",     32'(pc),        32'h04);
    ack_en = 1'b1;
    phase  = 2'd1;
    step(1);
    phase = 2'd0;
    step(2);
    check("err_trig_req",   32'(mem_req),   32'd0);
    check("err_trig_busy",  32'(busy),      32'd0);
    check("err_sticky",     32'(fetch_err), 32'd1);
    check("err_instr_hold", instr,          32'h44332211);
    phase = 2'd1;
    reset = 1'b1;
    step(1);
    check("to_rst_err",   32'(fetch_err), 32'd0);
    check("to_rst_pc",    32'(pc),        32'h00);
    check("to_rst_instr", instr,          32'h0);
    reset = 1'b0;
    step(1);

    // Reset after byte 2 is captured (edge T+3)
    phase = 2'd0;
    step(4);
    check("mr_instr_part", instr, 32'h00332211);
    reset = 1'b1;
    phase = 2'd1;
    step(1);
    check("mr_instr", instr,            32'h0);
    check("mr_pc",    32'(pc),          32'h00);
    check("mr_req",   32'(mem_req),     32'd0);
    check("mr_busy",  32'(busy),        32'd0);
    check("mr_valid", 32'(instr_valid), 32'd0);
    check("mr_addr",  32'(mem_addr),    32'h00);
    reset = 1'b0;
    step(1);
    phase = 2'd0;
    step(1);
    check("mr_refetch_addr", 32'(mem_addr), 32'h00);
    check("mr_refetch_req",  32'(mem_req),  32'd1);
    step(4);
    check("mr_refetch_instr", instr,   32'h44332211);
    check("mr_refetch_pc",    32'(pc), 32'h04);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
